// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared definitions for the memory access controller.
//   mc_state_e : controller state codes (MC_IDLE, MC_LO, MC_HI, MC_DONE)
//   BUS_BYTE_W : width of the external memory data bus
package mem_ctrl_pkg;

  localparam int unsigned BUS_BYTE_W = 8;

  typedef enum logic [1:0] {
    MC_IDLE = 2'd0,
    MC_LO   = 2'd1,
    MC_HI   = 2'd2,
    MC_DONE = 2'd3
  } mc_state_e;

endpackage

// File: rtl/mem_watchdog.sv
// mem_watchdog: per-beat ack wait counter for mem_ctrl.
// Only instantiated when MEM_CTRL_TIMEOUT_EN is defined.
//   I_clk, I_reset : clock, synchronous active-high reset
//   active_i       : controller is waiting on a bus beat (LO or HI)
//   ack_i          : bus beat acknowledged this cycle
//   expired_o      : this cycle is the TIMEOUT_CYCLES-th cycle without ack
module mem_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic I_clk,
  input  logic I_reset,
  input  logic active_i,
  input  logic ack_i,
  output logic expired_o
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] count_q, count_d;

  // Counter sits at zero outside a beat and restarts on every ack, so it is
  // cleared on entry to both LO and HI.
  always_comb begin
    count_d = count_q;
    if (!active_i || ack_i) begin
      count_d = '0;
    end else begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Fires on the cycle whose increment would reach TIMEOUT_CYCLES, so the
  // request is held for exactly TIMEOUT_CYCLES unacknowledged cycles.
  assign expired_o = active_i && !ack_i && (count_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: 16-bit memory access controller over an 8-bit req/ack bus.
// A one-cycle I_execute pulse starts a read or write, done as two byte beats,
// low byte first. All outputs are registered.
// Optional feature macro: MEM_CTRL_TIMEOUT_EN (per-beat ack timeout, O_error).
// Ports:
//   I_clk, I_reset            clock, synchronous active-high reset
//   I_execute, I_we           request pulse and direction (1=write)
//   I_addr, I_data            byte address (bit 0 ignored), write word
//   O_mem_ready               idle, a new request is accepted
//   O_data_ready, O_data      one-cycle read-complete pulse, read word
//   O_bus_req, O_bus_we       bus beat request, bus write strobe
//   O_bus_addr, O_bus_wdata   bus byte address, bus write byte
//   I_bus_ack, I_bus_rdata    beat complete pulse, read byte
//   O_error                   sticky timeout flag (MEM_CTRL_TIMEOUT_EN only)
// Bus handshake: a beat is offered while O_bus_req=1 with O_bus_addr,
// O_bus_we and O_bus_wdata held stable; it completes on the cycle I_bus_ack=1,
// when I_bus_rdata is sampled. I_bus_ack outside a beat is ignored.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  I_clk,
  input  logic                  I_reset,
  input  logic                  I_execute,
  input  logic                  I_we,
  input  logic [ADDR_WIDTH-1:0] I_addr,
  input  logic [15:0]           I_data,
  output logic                  O_mem_ready,
  output logic                  O_data_ready,
  output logic [15:0]           O_data,
  output logic                  O_bus_req,
  output logic                  O_bus_we,
  output logic [ADDR_WIDTH-1:0] O_bus_addr,
  output logic [BUS_BYTE_W-1:0] O_bus_wdata,
  input  logic                  I_bus_ack,
  input  logic [BUS_BYTE_W-1:0] I_bus_rdata
`ifdef MEM_CTRL_TIMEOUT_EN
  ,
  output logic                  O_error
`endif
);

  mc_state_e             state_q, state_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]           wdata_q, wdata_d;
  logic [BUS_BYTE_W-1:0] lo_q, lo_d;
  logic [15:0]           data_q, data_d;
  logic                  rd_ok_q, rd_ok_d;
  logic                  mem_ready_q, mem_ready_d;
  logic                  data_ready_q, data_ready_d;
  logic                  bus_req_q, bus_req_d;
  logic                  bus_we_q, bus_we_d;
  logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
  logic [BUS_BYTE_W-1:0] bus_wdata_q, bus_wdata_d;
  logic                  error_q, error_d;
  logic                  timeout;

`ifdef MEM_CTRL_TIMEOUT_EN
  mem_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .I_clk    (I_clk),
    .I_reset  (I_reset),
    .active_i ((state_q == MC_LO) || (state_q == MC_HI)),
    .ack_i    (I_bus_ack),
    .expired_o(timeout)
  );
  assign O_error = error_q;
`else
  assign timeout = 1'b0;
`endif

  // Address bit 0 is replaced by the beat index; the parameter is only
  // consumed by the optional watchdog.
  logic unused_inputs;
  assign unused_inputs = I_addr[0] ^ (TIMEOUT_CYCLES == 0);

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    lo_d         = lo_q;
    data_d       = data_q;
    rd_ok_d      = rd_ok_q;
    mem_ready_d  = mem_ready_q;
    data_ready_d = 1'b0;
    bus_req_d    = bus_req_q;
    bus_we_d     = bus_we_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    error_d      = error_q;

    unique case (state_q)
      MC_IDLE: begin
        mem_ready_d = 1'b1;
        if (I_execute) begin
          we_d        = I_we;
          addr_d      = I_addr;
          wdata_d     = I_data;
          rd_ok_d     = 1'b0;
          mem_ready_d = 1'b0;
          bus_req_d   = 1'b1;
          bus_we_d    = I_we;
          bus_addr_d  = {I_addr[ADDR_WIDTH-1:1], 1'b0};
          bus_wdata_d = I_data[7:0];
          state_d     = MC_LO;
        end
      end

      MC_LO: begin
        if (I_bus_ack) begin
          if (!we_q) begin
            lo_d = I_bus_rdata;
          end
          bus_addr_d  = {addr_q[ADDR_WIDTH-1:1], 1'b1};
          bus_wdata_d = wdata_q[15:8];
          state_d     = MC_HI;
        end else if (timeout) begin
          bus_req_d = 1'b0;
          bus_we_d  = 1'b0;
          error_d   = 1'b1;
          state_d   = MC_DONE;
        end
      end

      MC_HI: begin
        if (I_bus_ack) begin
          bus_req_d = 1'b0;
          bus_we_d  = 1'b0;
          if (!we_q) begin
            data_d  = {I_bus_rdata, lo_q};
            rd_ok_d = 1'b1;
          end
          state_d = MC_DONE;
        end else if (timeout) begin
          bus_req_d = 1'b0;
          bus_we_d  = 1'b0;
          error_d   = 1'b1;
          state_d   = MC_DONE;
        end
      end

      MC_DONE: begin
        // Only a read that finished both beats raises the data pulse.
        mem_ready_d  = 1'b1;
        data_ready_d = rd_ok_q;
        rd_ok_d      = 1'b0;
        state_d      = MC_IDLE;
      end

      default: state_d = MC_IDLE;
    endcase
  end

  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      state_q      <= MC_IDLE;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      lo_q         <= '0;
      data_q       <= '0;
      rd_ok_q      <= 1'b0;
      mem_ready_q  <= 1'b1;
      data_ready_q <= 1'b0;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      lo_q         <= lo_d;
      data_q       <= data_d;
      rd_ok_q      <= rd_ok_d;
      mem_ready_q  <= mem_ready_d;
      data_ready_q <= data_ready_d;
      bus_req_q    <= bus_req_d;
      bus_we_q     <= bus_we_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      error_q      <= error_d;
    end
  end

  assign O_mem_ready  = mem_ready_q;
  assign O_data_ready = data_ready_q;
  assign O_data       = data_q;
  assign O_bus_req    = bus_req_q;
  assign O_bus_we     = bus_we_q;
  assign O_bus_addr   = bus_addr_q;
  assign O_bus_wdata  = bus_wdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: self-checking bench for mem_ctrl. Table of transactions with
// hand-computed expectations, random transactions, and hand-written corner
// sequences. Read results go through an expected queue checked on each
// O_data_ready pulse.
module tb_mem_ctrl;

  logic        clk;
  logic        rst;
  logic        execute;
  logic        we;
  logic [15:0] addr;
  logic [15:0] data;
  logic        mem_ready;
  logic        data_ready;
  logic [15:0] rdata_out;
  logic        bus_req;
  logic        bus_we;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic        bus_ack;
  logic [7:0]  bus_rdata;
`ifdef MEM_CTRL_TIMEOUT_EN
  logic        error;
`endif

  mem_ctrl #(
    .ADDR_WIDTH    (16),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .I_clk       (clk),
    .I_reset     (rst),
    .I_execute   (execute),
    .I_we        (we),
    .I_addr      (addr),
    .I_data      (data),
    .O_mem_ready (mem_ready),
    .O_data_ready(data_ready),
    .O_data      (rdata_out),
    .O_bus_req   (bus_req),
    .O_bus_we    (bus_we),
    .O_bus_addr  (bus_addr),
    .O_bus_wdata (bus_wdata),
    .I_bus_ack   (bus_ack),
    .I_bus_rdata (bus_rdata)
`ifdef MEM_CTRL_TIMEOUT_EN
    ,
    .O_error     (error)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation time limit reached, required finish");
    $fatal(1, "bench did not finish");
  end

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          dr_cnt = 0;
  logic        dr_prev = 1'b0;
  logic [15:0] last_data = 16'h0000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Pop and compare on every read completion; also enforce a one-cycle pulse.
  always @(negedge clk) begin
    if (!rst) begin
      if (data_ready) begin
        dr_cnt++;
        chk("data_ready_single_cycle", {31'd0, dr_prev}, 32'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_data_ready", 32'd1, 32'd0);
        end else begin
          logic [15:0] e;
          e = exp_q.pop_front();
          chk("read_data", {16'd0, rdata_out}, {16'd0, e});
          last_data = e;
        end
      end
      dr_prev = data_ready;
    end else begin
      dr_prev = 1'b0;
    end
  end

  // ---------------- vectors ----------------
  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] data;
    logic [7:0]  rlo;
    logic [7:0]  rhi;
    int          dlo;
    int          dhi;
    logic        busy;     // pulse a second execute during the low beat
    logic [15:0] e_alo;
    logic [15:0] e_ahi;
    logic [7:0]  e_wlo;
    logic [7:0]  e_whi;
    logic [15:0] e_data;
    int          e_lat;
  } vec_t;

  vec_t vecs[6];

  task automatic do_reset();
    rst = 1'b1; execute = 1'b0; we = 1'b0; addr = '0; data = '0;
    bus_ack = 1'b0; bus_rdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_beat(input vec_t v, input int b);
    chk("beat_req", {31'd0, bus_req}, 32'd1);
    chk("beat_we", {31'd0, bus_we}, {31'd0, v.we});
    chk("beat_addr", {16'd0, bus_addr}, {16'd0, (b == 0) ? v.e_alo : v.e_ahi});
    chk("beat_mem_ready", {31'd0, mem_ready}, 32'd0);
    if (v.we) chk("beat_wdata", {24'd0, bus_wdata}, {24'd0, (b == 0) ? v.e_wlo : v.e_whi});
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int n;
    int dr0;
    int dl;
    dr0 = dr_cnt;
    @(negedge clk);
    chk({tag, "_idle_ready"}, {31'd0, mem_ready}, 32'd1);
    execute = 1'b1; we = v.we; addr = v.addr; data = v.data;
    if (!v.we) exp_q.push_back(v.e_data);
    n = 0;
    for (int b = 0; b < 2; b++) begin
      @(negedge clk); n++;
      bus_ack = 1'b0;
      execute = 1'b0;
      if (b == 0 && v.busy) begin
        execute = 1'b1; we = 1'b1; addr = 16'h0080; data = 16'h1111;
      end
      chk_beat(v, b);
      dl = (b == 0) ? v.dlo : v.dhi;
      for (int d = 0; d < dl; d++) begin
        @(negedge clk); n++;
        execute = 1'b0;
        chk_beat(v, b);
      end
      bus_ack = 1'b1;
      bus_rdata = (b == 0) ? v.rlo : v.rhi;
    end
    @(negedge clk); n++;
    bus_ack = 1'b0; bus_rdata = 8'h00;
    chk({tag, "_done_req"}, {31'd0, bus_req}, 32'd0);
    chk({tag, "_done_we"}, {31'd0, bus_we}, 32'd0);
    while (!mem_ready && n < 40) begin
      @(negedge clk); n++;
    end
    chk({tag, "_latency"}, n, v.e_lat);
    @(negedge clk);
    chk({tag, "_data_ready_count"}, dr_cnt - dr0, v.we ? 0 : 1);
    chk({tag, "_data_hold"}, {16'd0, rdata_out}, {16'd0, last_data});
    if (v.busy) begin
      repeat (3) begin
        @(negedge clk);
        chk({tag, "_no_extra_beat"}, {31'd0, bus_req}, 32'd0);
      end
    end
  endtask

  function automatic vec_t rand_vec();
    vec_t v;
    v.we    = 1'($urandom_range(0, 1));
    v.addr  = 16'($urandom_range(0, 65535));
    v.data  = 16'($urandom_range(0, 65535));
    v.rlo   = 8'($urandom_range(0, 255));
    v.rhi   = 8'($urandom_range(0, 255));
    v.dlo   = $urandom_range(0, 3);
    v.dhi   = $urandom_range(0, 3);
    v.busy  = 1'b0;
    v.e_alo = {v.addr[15:1], 1'b0};
    v.e_ahi = {v.addr[15:1], 1'b1};
    v.e_wlo = v.data[7:0];
    v.e_whi = v.data[15:8];
    v.e_data = {v.rhi, v.rlo};
    v.e_lat = 4 + v.dlo + v.dhi;
    return v;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    //          we    addr      data      rlo    rhi   dlo dhi busy  e_alo     e_ahi     e_wlo  e_whi  e_data    lat
    vecs[0] = '{1'b0, 16'h0010, 16'h0000, 8'h34, 8'h12, 0, 0, 1'b0, 16'h0010, 16'h0011, 8'h00, 8'h00, 16'h1234, 4};
    vecs[1] = '{1'b1, 16'h0020, 16'hBEEF, 8'h00, 8'h00, 0, 0, 1'b0, 16'h0020, 16'h0021, 8'hEF, 8'hBE, 16'h0000, 4};
    vecs[2] = '{1'b0, 16'h0031, 16'h0000, 8'hAB, 8'hCD, 3, 3, 1'b0, 16'h0030, 16'h0031, 8'h00, 8'h00, 16'hCDAB, 10};
    vecs[3] = '{1'b1, 16'h00FF, 16'h5A96, 8'h00, 8'h00, 1, 2, 1'b0, 16'h00FE, 16'h00FF, 8'h96, 8'h5A, 16'h0000, 7};
    vecs[4] = '{1'b0, 16'hFFFE, 16'h0000, 8'h00, 8'hFF, 2, 0, 1'b0, 16'hFFFE, 16'hFFFF, 8'h00, 8'h00, 16'hFF00, 6};
    vecs[5] = '{1'b0, 16'h0040, 16'h0000, 8'h77, 8'h66, 2, 0, 1'b1, 16'h0040, 16'h0041, 8'h00, 8'h00, 16'h6677, 6};

    do_reset();
    chk("rst_mem_ready", {31'd0, mem_ready}, 32'd1);
    chk("rst_data_ready", {31'd0, data_ready}, 32'd0);
    chk("rst_data", {16'd0, rdata_out}, 32'd0);
    chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
    chk("rst_bus_we", {31'd0, bus_we}, 32'd0);
    chk("rst_bus_addr", {16'd0, bus_addr}, 32'd0);
    chk("rst_bus_wdata", {24'd0, bus_wdata}, 32'd0);
`ifdef MEM_CTRL_TIMEOUT_EN
    chk("rst_error", {31'd0, error}, 32'd0);
`endif

    // Reset during the high beat of a read: partial read discarded.
    @(negedge clk);
    execute = 1'b1; we = 1'b0; addr = 16'h0100;
    @(negedge clk);
    execute = 1'b0; bus_ack = 1'b1; bus_rdata = 8'h5C;
    @(negedge clk);
    bus_ack = 1'b0;
    chk("mid_hi_addr", {16'd0, bus_addr}, 32'h0101);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_req", {31'd0, bus_req}, 32'd0);
    chk("mid_rst_ready", {31'd0, mem_ready}, 32'd1);
    chk("mid_rst_data", {16'd0, rdata_out}, 32'd0);
    repeat (3) @(negedge clk);
    chk("mid_rst_no_pulse", {31'd0, data_ready}, 32'd0);

    // Table-driven transactions.
    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Random transactions checked against the same beat model.
    for (int i = 0; i < 8; i++) run_vec(rand_vec(), $sformatf("rnd%0d", i));

    // Ack while idle has no effect.
    @(negedge clk);
    bus_ack = 1'b1; bus_rdata = 8'hEE;
    @(negedge clk);
    bus_ack = 1'b0;
    @(negedge clk);
    chk("idle_ack_req", {31'd0, bus_req}, 32'd0);
    chk("idle_ack_ready", {31'd0, mem_ready}, 32'd1);
    chk("idle_ack_data", {16'd0, rdata_out}, {16'd0, last_data});

`ifdef MEM_CTRL_TIMEOUT_EN
    // No ack at all: request held for TIMEOUT_CYCLES cycles, then dropped.
    begin
      int hi_cycles;
      int n;
      int dr0;
      dr0 = dr_cnt;
      @(negedge clk);
      execute = 1'b1; we = 1'b0; addr = 16'h0200;
      @(negedge clk);
      execute = 1'b0;
      hi_cycles = 0;
      while (bus_req && hi_cycles < 20) begin
        hi_cycles++;
        @(negedge clk);
      end
      chk("to_req_cycles", hi_cycles, 4);
      chk("to_error", {31'd0, error}, 32'd1);
      n = 0;
      while (!mem_ready && n < 20) begin
        @(negedge clk); n++;
      end
      chk("to_ready", {31'd0, mem_ready}, 32'd1);
      repeat (2) @(negedge clk);
      chk("to_no_pulse", dr_cnt - dr0, 0);
      chk("to_data_hold", {16'd0, rdata_out}, {16'd0, last_data});
      chk("to_error_sticky", {31'd0, error}, 32'd1);
    end
`endif

    repeat (2) @(negedge clk);
    chk("exp_q_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
